// File: rtl/alu_fib_sequencer.sv
// Purpose: sequences ADD/SUB operations on an external combinational ALU to compute F(n).
// Latency: done pulses 2 + 3*n cycles after the edge that accepts start.
// Backpressure: start is ignored while busy; result/overflow are held until the next done.
module alu_fib_sequencer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] n_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         overflow,
  output logic [N-1:0] alu_src1,
  output logic [N-1:0] alu_src2,
  output logic [3:0]   alucontrol,
  input  logic [N-1:0] alu_result,
  input  logic         alu_zero
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ADD   = 3'd2,
    S_DEC   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t       state_q;
  logic [N-1:0] a_q;       // F(i)
  logic [N-1:0] b_q;       // F(i+1)
  logic [N-1:0] k_q;       // iterations still to run
  logic         ova_q;     // a_q has wrapped at some point
  logic         ovb_q;     // b_q has wrapped at some point
  logic         busy_q;
  logic         done_q;
  logic [N-1:0] result_q;
  logic         overflow_q;
  logic         ovb_d;

  // ALU operand/opcode drive, decoded from the current state.
  always_comb begin
    alucontrol = OP_ADD;
    alu_src1   = '0;
    alu_src2   = '0;
    case (state_q)
      S_CHECK: begin
        alucontrol = OP_SUB;
        alu_src1   = k_q;
        alu_src2   = '0;
      end
      S_ADD: begin
        alucontrol = OP_ADD;
        alu_src1   = a_q;
        alu_src2   = b_q;
      end
      S_DEC: begin
        alucontrol = OP_SUB;
        alu_src1   = k_q;
        alu_src2   = N'(1);
      end
      default: begin
        alucontrol = OP_ADD;
        alu_src1   = '0;
        alu_src2   = '0;
      end
    endcase
  end

  // A sum smaller than one addend means the add carried out; the wrap flag is sticky.
  always_comb begin
    ovb_d = ovb_q | (alu_result < b_q);
  end

  // Control FSM with registered status outputs; k is decremented only through the ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      k_q        <= '0;
      ova_q      <= 1'b0;
      ovb_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= '0;
            b_q     <= N'(1);
            ova_q   <= 1'b0;
            ovb_q   <= 1'b0;
            k_q     <= n_in;
            busy_q  <= 1'b1;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (alu_zero) begin
            result_q   <= a_q;
            overflow_q <= ova_q;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          a_q     <= b_q;
          ova_q   <= ovb_q;
          b_q     <= alu_result;
          ovb_q   <= ovb_d;
          state_q <= S_DEC;
        end
        S_DEC: begin
          k_q     <= alu_result;
          state_q <= S_CHECK;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: doc/alu_fib_sequencer.md
Name: alu_fib_sequencer

Overview:
Multi-cycle controller that drives the datapath ALU from the operand/opcode side and consumes its result and zero flag. It computes the unsigned Fibonacci number F(n) by issuing ADD and SUB operations to the ALU, one per cycle. Loop termination uses only the ALU zero flag. It sits between the top-level start/result interface and the combinational ALU, and is the first block that exercises the ALU under sequential control.

Parameters:
N, 32, datapath width of operands, result and iteration count.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request a new computation; sampled only in IDLE.
n_in  in  N  requested Fibonacci index, unsigned; captured when start is accepted.
busy  out  1  high from the cycle after start is accepted through the DONE cycle inclusive.
done  out  1  one-cycle pulse; result and overflow are valid in this cycle and remain held afterwards.
result  out  N  F(n) modulo 2^N.
overflow  out  1  high if F(n) does not fit in N bits.
alu_src1  out  N  first ALU operand.
alu_src2  out  N  second ALU operand.
alucontrol  out  4  ALU opcode: ADD = 4'h0, SUB = 4'h1. No other codes are driven.
alu_result  in  N  combinational ALU result for the current cycle's operands.
alu_zero  in  1  combinational ALU zero flag; high when alu_result == 0.

Behaviour:
- Reset (async, any state): state = IDLE; busy = 0, done = 0, result = 0, overflow = 0; internal a, b, k and overflow bits cleared.
- Internal registers: a (N bits), b (N bits), k (N bits), plus wrap bits ova and ovb.
- IDLE:
  - Drives alucontrol = ADD, alu_src1 = 0, alu_src2 = 0.
  - On start = 1: load a = 0, b = 1, ova = 0, ovb = 0, k = n_in; go to CHECK.
- CHECK:
  - Drives SUB with src1 = k, src2 = 0.
  - If alu_zero = 1: result <= a, overflow <= ova; go to DONE.
  - Otherwise: go to ADD.
- ADD:
  - Drives ADD with src1 = a, src2 = b.
  - Updates a <= b, ova <= ovb, b <= alu_result.
  - ovb <= ovb OR (alu_result < b), compared as unsigned (carry-out detect); the flag is sticky.
  - Go to DEC.
- DEC:
  - Drives SUB with src1 = k, src2 = 1.
  - Updates k <= alu_result; go to CHECK.
- DONE:
  - done = 1 for exactly this cycle; busy = 1.
  - ALU outputs are driven as in IDLE.
  - Go to IDLE.
- Timing:
  - Each loop iteration takes 3 cycles (CHECK, ADD, DEC).
  - If start is sampled at edge E0, the first CHECK is the cycle after E0 and done is high in cycle 2 + 3n after E0.
  - Minimum latency is n = 0, with done in cycle 2.
- start while busy: ignored; no restart and no queuing.
- start held high continuously: a new computation is accepted on the first IDLE cycle after DONE.
- result and overflow hold their values between done pulses. They change only in the CHECK-exit cycle, observable at done.
- Arithmetic: all unsigned, modulo 2^N.
  - overflow reflects the wrap history of the value returned as F(n), not of F(n+1), which is also computed.
- k is always decremented via the ALU; no local subtractor or comparator is used for termination.
- rst asserted mid-operation: immediate return to IDLE with all outputs cleared; no done pulse.

Test Plan:
- Reset, then start with n_in = 0 -> one CHECK (SUB 0 - 0, zero = 1); done in cycle 2; result = 0; overflow = 0; busy high in cycles 1 and 2.
- n_in = 1 -> done in cycle 5, result = 1. ALU opcode trace must be SUB, ADD, SUB, SUB with operands (1,0), (0,1), (1,1), (0,0).
- n_in = 10 -> done in cycle 32, result = 55, overflow = 0. Then n_in = 47 -> result = 2971215073, overflow = 0.
- n_in = 48 -> result = 512559680 (4807526976 mod 2^32), overflow = 1. A following n_in = 5 -> result = 5, overflow = 0 (flag cleared on new start).
- Start n_in = 10, pulse start again with n_in = 3 in cycle 7 -> second request ignored; done in cycle 32 with result 55; exactly one done pulse.
- Start n_in = 20, assert rst in cycle 15 -> outputs immediately 0, no done pulse. After release, start n_in = 2 -> result = 1 in cycle 8.
